// File: rtl/fpu_rr_scheduler_pkg.sv
// Shared definitions for the round-robin fpu scheduler: fpu op/rmode codes,
// flag bit positions and the operand bundle handed to the fpu.
package fpu_rr_scheduler_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned RMODE_W = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FLAG_W  = 8;

    typedef enum logic [OP_W-1:0] {
        FPU_ADD = 3'd0,
        FPU_SUB = 3'd1,
        FPU_MUL = 3'd2,
        FPU_DIV = 3'd3
    } fpu_op_e;

    typedef enum logic [RMODE_W-1:0] {
        RM_NEAREST = 2'd0,
        RM_ZERO    = 2'd1,
        RM_POS_INF = 2'd2,
        RM_NEG_INF = 2'd3
    } fpu_rmode_e;

    // Bit positions within the 8-bit fpu flag vector
    localparam int unsigned FLAG_INF         = 7;
    localparam int unsigned FLAG_SNAN        = 6;
    localparam int unsigned FLAG_QNAN        = 5;
    localparam int unsigned FLAG_INE         = 4;
    localparam int unsigned FLAG_OVERFLOW    = 3;
    localparam int unsigned FLAG_UNDERFLOW   = 2;
    localparam int unsigned FLAG_ZERO        = 1;
    localparam int unsigned FLAG_DIV_BY_ZERO = 0;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [RMODE_W-1:0] rmode;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
    } fpu_req_t;

endpackage

// File: rtl/fpu_rr_scheduler_arb.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping,
// returned as a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] id,
    output logic           any
);

    always_comb begin
        int unsigned idx;
        logic [N-1:0] sh;
        gnt = '0;
        id  = '0;
        any = 1'b0;
        idx = 0;
        sh  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            sh  = req >> idx;
            if (!any && sh[0]) begin
                any = 1'b1;
                gnt = N'(1) << idx;
                id  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Shares one fixed-latency pipelined fpu between NREQ requesters; a tag pipe
// tracks each issued op so its result is steered back to the issuer.
module fpu_rr_scheduler
    import fpu_rr_scheduler_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned FPU_LAT = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_en,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [OP_W*NREQ-1:0]      req_op,
    input  logic [RMODE_W*NREQ-1:0]   req_rmode,
    input  logic [DATA_W*NREQ-1:0]    req_a,
    input  logic [DATA_W*NREQ-1:0]    req_b,
    output logic [OP_W-1:0]           fpu_op,
    output logic [RMODE_W-1:0]        fpu_rmode,
    output logic [DATA_W-1:0]         fpu_opa,
    output logic [DATA_W-1:0]         fpu_opb,
    input  logic [DATA_W-1:0]         fpu_out,
    input  logic [FLAG_W-1:0]         fpu_flags,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]         rsp_out,
    output logic [FLAG_W-1:0]         rsp_flags,
    output logic                      busy
);

    logic [IDW-1:0]           ptr;
    logic [NREQ-1:0]          win_gnt;
    logic [IDW-1:0]           win_id;
    logic                     win_any;
    fpu_req_t                 sel_req;
    fpu_req_t                 fpu_q;
    logic [FPU_LAT:0]         tag_vld;
    logic [FPU_LAT:0][IDW-1:0] tag_id;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .req (req_valid & {NREQ{issue_en}}),
        .ptr (ptr),
        .gnt (win_gnt),
        .id  (win_id),
        .any (win_any)
    );

    assign req_ready = win_gnt;

    // One-hot AND-OR mux of the winner's operand bundle
    always_comb begin
        sel_req = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_gnt[i]) begin
                sel_req.op    = req_op[OP_W*i +: OP_W];
                sel_req.rmode = req_rmode[RMODE_W*i +: RMODE_W];
                sel_req.a     = req_a[DATA_W*i +: DATA_W];
                sel_req.b     = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    // Operand registers, rr pointer and the free-running tag shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            fpu_q   <= '0;
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld <= {tag_vld[FPU_LAT-1:0], win_any};
            tag_id  <= {tag_id[FPU_LAT-1:0], win_id};
            if (win_any) begin
                fpu_q <= sel_req;
                ptr   <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
            end
        end
    end

    assign fpu_op    = fpu_q.op;
    assign fpu_rmode = fpu_q.rmode;
    assign fpu_opa   = fpu_q.a;
    assign fpu_opb   = fpu_q.b;

    // Last tag stage lines up with fpu_out for the op it describes
    always_comb begin
        rsp_valid = '0;
        if (tag_vld[FPU_LAT]) begin
            rsp_valid = NREQ'(1) << tag_id[FPU_LAT];
        end
    end

    assign rsp_out   = fpu_out;
    assign rsp_flags = fpu_flags;
    assign busy      = |tag_vld;

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Scoreboard bench for fpu_rr_scheduler with a small lookup fpu model of latency FPU_LAT.
module tb_fpu_rr_scheduler;
    import fpu_rr_scheduler_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned FPU_LAT = 4;
    localparam int unsigned IDW     = 2;
    localparam int          RSP_LAT = int'(FPU_LAT) + 1;

    logic                  clk      = 1'b0;
    logic                  rst_n    = 1'b0;
    logic                  issue_en = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [2*NREQ-1:0]     req_rmode;
    logic [32*NREQ-1:0]    req_a;
    logic [32*NREQ-1:0]    req_b;
    logic [2:0]            fpu_op;
    logic [1:0]            fpu_rmode;
    logic [31:0]           fpu_opa;
    logic [31:0]           fpu_opb;
    logic [31:0]           fpu_out;
    logic [7:0]            fpu_flags;
    logic [NREQ-1:0]       rsp_valid;
    logic [31:0]           rsp_out;
    logic [7:0]            rsp_flags;
    logic                  busy;

    logic [2:0]  vec_op  [NREQ];
    logic [1:0]  vec_rm  [NREQ];
    logic [31:0] vec_a   [NREQ];
    logic [31:0] vec_b   [NREQ];
    logic [31:0] vec_out [NREQ];
    logic [7:0]  vec_flg [NREQ];

    typedef struct {
        int          id;
        logic [31:0] out;
        logic [7:0]  flags;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   last_acc = 0;

    fpu_rr_scheduler #(
        .NREQ    (NREQ),
        .FPU_LAT (FPU_LAT),
        .IDW     (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue_en  (issue_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rmode (req_rmode),
        .req_a     (req_a),
        .req_b     (req_b),
        .fpu_op    (fpu_op),
        .fpu_rmode (fpu_rmode),
        .fpu_opa   (fpu_opa),
        .fpu_opb   (fpu_opb),
        .fpu_out   (fpu_out),
        .fpu_flags (fpu_flags),
        .rsp_valid (rsp_valid),
        .rsp_out   (rsp_out),
        .rsp_flags (rsp_flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_op[3*i +: 3]     = vec_op[i];
            req_rmode[2*i +: 2]  = vec_rm[i];
            req_a[32*i +: 32]    = vec_a[i];
            req_b[32*i +: 32]    = vec_b[i];
        end
    end

    // Lookup fpu: only the operand pairs used by this bench return real IEEE results
    function automatic logic [39:0] fpu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        if (op == 3'(FPU_ADD) && a == 32'h3F800000 && b == 32'h40000000) return {8'h00, 32'h40400000};
        if (op == 3'(FPU_SUB) && a == 32'h40400000 && b == 32'h3F800000) return {8'h00, 32'h40000000};
        if (op == 3'(FPU_MUL) && a == 32'h40000000 && b == 32'h40400000) return {8'h00, 32'h40C00000};
        if (op == 3'(FPU_ADD) && a == 32'h40000000 && b == 32'h40000000) return {8'h00, 32'h40800000};
        if (op == 3'(FPU_DIV) && a == 32'h3F800000 && b == 32'h00000000) return {8'h81, 32'h7F800000};
        return {8'h00, a ^ b ^ 32'hA5A5A5A5};
    endfunction

    logic [39:0] fpu_pipe [FPU_LAT];
    always @(posedge clk) begin
        fpu_pipe[0] <= fpu_model(fpu_op, fpu_opa, fpu_opb);
        for (int k = 1; k < FPU_LAT; k++) fpu_pipe[k] <= fpu_pipe[k-1];
    end
    assign fpu_out   = fpu_pipe[FPU_LAT-1][31:0];
    assign fpu_flags = fpu_pipe[FPU_LAT-1][39:32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every response strobe is matched against the oldest expected entry
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id",    64'(rsp_valid), 64'(NREQ'(1) << e.id));
                chk("rsp_out",   64'(rsp_out),   64'(e.out));
                chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
                chk("rsp_cycle", 64'(cyc),       64'(e.cyc));
            end
        end
    end

    // One cycle: check the grant, log the expected response, then check the operand registers
    task automatic step(input logic [NREQ-1:0] exp_rdy, input string name);
        int          id;
        exp_t        e;
        logic [2:0]  x_op;
        logic [1:0]  x_rm;
        logic [31:0] x_a;
        logic [31:0] x_b;
        id = -1;
        x_op = '0; x_rm = '0; x_a = '0; x_b = '0;
        #1;
        chk(name, 64'(req_ready), 64'(exp_rdy));
        for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) id = i;
        if (id >= 0) begin
            e.id = id; e.out = vec_out[id]; e.flags = vec_flg[id]; e.cyc = cyc + RSP_LAT;
            sb.push_back(e);
            last_acc = cyc;
            x_op = vec_op[id]; x_rm = vec_rm[id]; x_a = vec_a[id]; x_b = vec_b[id];
        end
        @(posedge clk); #1;
        if (id >= 0) begin
            chk("fpu_op",    64'(fpu_op),    64'(x_op));
            chk("fpu_rmode", 64'(fpu_rmode), 64'(x_rm));
            chk("fpu_opa",   64'(fpu_opa),   64'(x_a));
            chk("fpu_opb",   64'(fpu_opb),   64'(x_b));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < RSP_LAT + 2; i++) step('0, "idle_ready");
    endtask

    task automatic set_default_vecs();
        vec_op[0] = 3'(FPU_ADD); vec_a[0] = 32'h3F800000; vec_b[0] = 32'h40000000; vec_out[0] = 32'h40400000;
        vec_op[1] = 3'(FPU_SUB); vec_a[1] = 32'h40400000; vec_b[1] = 32'h3F800000; vec_out[1] = 32'h40000000;
        vec_op[2] = 3'(FPU_MUL); vec_a[2] = 32'h40000000; vec_b[2] = 32'h40400000; vec_out[2] = 32'h40C00000;
        vec_op[3] = 3'(FPU_ADD); vec_a[3] = 32'h40000000; vec_b[3] = 32'h40000000; vec_out[3] = 32'h40800000;
        for (int i = 0; i < NREQ; i++) begin
            vec_rm[i]  = 2'(i);
            vec_flg[i] = 8'h00;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        set_default_vecs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_fpu_op",    64'(fpu_op),    64'(0));
        chk("rst_fpu_opa",   64'(fpu_opa),   64'(0));
        chk("rst_ready",     64'(req_ready), 64'(0));
        rst_n    = 1'b1;
        issue_en = 1'b1;

        // All four continuously valid: strict rotation from ptr 0
        req_valid = '1;
        for (int i = 0; i < 8; i++) step(NREQ'(1) << (i % NREQ), "grant_rr");
        req_valid = '0;
        drain();

        // Single ADD from requester 0
        req_valid = 4'b0001;
        step(4'b0001, "single_gnt");
        req_valid = '0;
        drain();

        // Requester 2 divides by zero (ptr is 1 here)
        vec_op[2] = 3'(FPU_DIV); vec_a[2] = 32'h3F800000; vec_b[2] = 32'h00000000;
        vec_out[2] = 32'h7F800000; vec_flg[2] = 8'h81;
        req_valid = 4'b0100;
        step(4'b0100, "div_gnt");
        req_valid = '0;
        drain();
        set_default_vecs();

        // Pointer wrap: ptr is 3 after the divide
        req_valid = 4'b1000;
        step(4'b1000, "wrap_gnt3");
        req_valid = 4'b1001;
        step(4'b0001, "wrap_gnt0");
        step(4'b1000, "wrap_gnt3b");
        req_valid = '0;
        drain();

        // issue_en low stops grants while issued ops drain
        req_valid = '1;
        step(4'b0001, "pre_hold_gnt0");
        step(4'b0010, "pre_hold_gnt1");
        issue_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("hold_busy", 64'(busy), 64'(cyc <= last_acc + RSP_LAT));
            step('0, "hold_ready");
        end
        issue_en = 1'b1;

        // Reset with three ops in flight (ptr is 2)
        step(4'b0100, "pre_rst_gnt2");
        step(4'b1000, "pre_rst_gnt3");
        step(4'b0001, "pre_rst_gnt0");
        req_valid = '0;
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mid_rst_busy",  64'(busy),      64'(0));
            chk("mid_rst_rsp",   64'(rsp_valid), 64'(0));
            @(posedge clk);
        end
        #1;
        rst_n = 1'b1;
        req_valid = '1;
        step(4'b0001, "post_rst_gnt0");
        req_valid = '0;
        drain();
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
